// File: rtl/sram_audio_pkg.sv
// Shared state type and constants for the SRAM PCM player and its rate divider.
package sram_audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT
    } player_state_t;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    localparam int DIV_44K1  = 1134;
    localparam int DIV_22K05 = 2268;

endpackage

// File: rtl/sram_pcm_player_if.sv
// Asynchronous SRAM read bus: the player drives address and controls, the memory returns DQ.
interface sram_pcm_player_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;
    logic [DATA_W-1:0] sram_dq;

    modport master (
        output sram_addr,
        output sram_ce_n,
        output sram_oe_n,
        output sram_we_n,
        output sram_ub_n,
        output sram_lb_n,
        input  sram_dq
    );

    modport slave (
        input  sram_addr,
        input  sram_ce_n,
        input  sram_oe_n,
        input  sram_we_n,
        input  sram_ub_n,
        input  sram_lb_n,
        output sram_dq
    );
endinterface

// File: rtl/sram_pcm_player_rate_divider.sv
// Frame-rate counter for the PCM player: counts unpaused busy cycles and ticks once per frame period.
module pcm_rate_divider
    import sram_audio_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] eff_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = run && (div_cnt == eff_div - DIV_W'(1));

    // The wrap to zero on tick keeps frames exactly eff_div cycles apart.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_pcm_player.sv
// Streams a windowed PCM clip from asynchronous SRAM to the codec at a programmable frame rate.
// Optional build macro VOLUME_EN adds a volume_shift input applied when a frame is latched.
module sram_pcm_player
    import sram_audio_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 16,
    parameter int SRAM_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  rate_div,
`ifdef VOLUME_EN
    input  logic [3:0]        volume_shift,
`endif
    sram_pcm_player_if.master sram,
    output logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] rdata,
    output logic              frame_valid,
    output logic              busy,
    output logic              done
);

    localparam int MIN_DIV = NUM_CH * (SRAM_WAIT + 1) + 2;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W  = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;

    player_state_t     state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] start_r;
    logic [ADDR_W-1:0] end_r;
    logic [DIV_W-1:0]  eff_div;
    logic [CH_W-1:0]   ch;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DATA_W-1:0] stage [NUM_CH];

    logic start_accept;
    logic past_end;
    logic frame_tick;

    // The extra ptr bit lets an end_addr at the top of memory be passed without wrapping to zero.
    assign past_end     = ptr > {1'b0, end_r};
    assign start_accept = start && (end_addr >= start_addr) && !(stop && state != IDLE);

    assign sram.sram_addr = ptr[ADDR_W-1:0];
    assign sram.sram_ce_n = 1'b0;
    assign sram.sram_oe_n = 1'b0;
    assign sram.sram_we_n = 1'b1;
    assign sram.sram_ub_n = 1'b0;
    assign sram.sram_lb_n = 1'b0;

    pcm_rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (start_accept),
        .run     ((state != IDLE) && !pause),
        .eff_div (eff_div),
        .tick    (frame_tick)
    );

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] sample);
`ifdef VOLUME_EN
        return DATA_W'($signed(sample) >>> volume_shift);
`else
        return sample;
`endif
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            start_r     <= '0;
            end_r       <= '0;
            eff_div     <= DIV_W'(MIN_DIV);
            ch          <= '0;
            hold_cnt    <= '0;
            ldata       <= '0;
            rdata       <= '0;
            frame_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            done        <= 1'b0;
            if (stop && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                ldata <= '0;
                rdata <= '0;
            end else if (start_accept) begin
                start_r  <= start_addr;
                end_r    <= end_addr;
                eff_div  <= (rate_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : rate_div;
                ptr      <= {1'b0, start_addr};
                ch       <= '0;
                hold_cnt <= '0;
                state    <= FETCH;
                busy     <= 1'b1;
            end else if (!pause) begin
                case (state)
                    IDLE: begin
                    end
                    FETCH: begin
                        // Words beyond the window pad the remainder of a partial frame with silence.
                        if (hold_cnt == HOLD_W'(SRAM_WAIT)) begin
                            hold_cnt  <= '0;
                            stage[ch] <= past_end ? '0 : sram.sram_dq;
                            ptr       <= ptr + (ADDR_W + 1)'(1);
                            if (ch == CH_W'(NUM_CH - 1)) begin
                                state <= WAIT;
                            end else begin
                                ch <= ch + CH_W'(1);
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    WAIT: begin
                        if (frame_tick) begin
                            ldata       <= scale(stage[0]);
                            rdata       <= scale(stage[NUM_CH-1]);
                            frame_valid <= 1'b1;
                            ch          <= '0;
                            if (past_end && !loop_en) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                if (past_end) begin
                                    ptr <= {1'b0, start_r};
                                end
                                state <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_pcm_player.sv
// Testbench for sram_pcm_player: directed vector table, hand-written corner sequences and randomized clips.
module tb_sram_pcm_player;
    import sram_audio_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    typedef struct {
        longint       t;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic         d;
    } ev_t;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        logic [15:0]   div;
        bit            lp;
        int            obs;
        int            exp_frames;
        int            exp_spacing;
        logic [15:0]   exp_l;
        logic [15:0]   exp_r;
        int            exp_dones;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start_st = 1'b0;
    logic          start_mo = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [15:0]   rate_div = 16'd20;
    logic [15:0]   mix = '0;

    logic [DW-1:0] ld_st, rd_st, ld_mo, rd_mo;
    logic          fv_st, fv_mo, done_st, done_mo, busy_st, busy_mo;
    logic [AW-1:0] last_st, last_mo;

    int checks = 0;
    int errors = 0;
    ev_t ev_st[$];
    ev_t ev_mo[$];

    sram_pcm_player_if #(.ADDR_W(AW), .DATA_W(DW)) bus_st ();
    sram_pcm_player_if #(.ADDR_W(AW), .DATA_W(DW)) bus_mo ();

    always #5 Clk = ~Clk;

    // SRAM model: data only becomes valid once the address has been held across a clock edge.
    always @(posedge Clk) begin
        last_st <= bus_st.sram_addr;
        last_mo <= bus_mo.sram_addr;
    end
    assign bus_st.sram_dq = (bus_st.sram_addr == last_st) ? (bus_st.sram_addr[15:0] ^ mix) : 16'hDEAD;
    assign bus_mo.sram_dq = (bus_mo.sram_addr == last_mo) ? (bus_mo.sram_addr[15:0] ^ mix) : 16'hDEAD;

    sram_pcm_player #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(2), .DIV_W(16), .SRAM_WAIT(1)) u_st (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start_st),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rate_div    (rate_div),
`ifdef VOLUME_EN
        .volume_shift(4'd0),
`endif
        .sram        (bus_st),
        .ldata       (ld_st),
        .rdata       (rd_st),
        .frame_valid (fv_st),
        .busy        (busy_st),
        .done        (done_st)
    );

    sram_pcm_player #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(1), .DIV_W(16), .SRAM_WAIT(1)) u_mo (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start_mo),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rate_div    (rate_div),
`ifdef VOLUME_EN
        .volume_shift(4'd0),
`endif
        .sram        (bus_mo),
        .ldata       (ld_mo),
        .rdata       (rd_mo),
        .frame_valid (fv_mo),
        .busy        (busy_mo),
        .done        (done_mo)
    );

    always @(negedge Clk) begin
        if (fv_st || done_st) ev_st.push_back('{$time, ld_st, rd_st, done_st});
        if (fv_mo || done_mo) ev_mo.push_back('{$time, ld_mo, rd_mo, done_mo});
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ev_count(input bit mono);
        return mono ? ev_mo.size() : ev_st.size();
    endfunction

    function automatic ev_t ev_get(input bit mono, input int k);
        return mono ? ev_mo[k] : ev_st[k];
    endfunction

    function automatic logic busy_of(input bit mono);
        return mono ? busy_mo : busy_st;
    endfunction

    function automatic logic [15:0] mem_word(input longint a);
        logic [15:0] lo;
        lo = a[15:0];
        return lo ^ mix;
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input bit mono, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic [15:0] div, input bit lp, output longint t0);
        @(negedge Clk);
        start_addr = sa;
        end_addr   = ea;
        rate_div   = div;
        loop_en    = lp;
        if (mono) start_mo = 1'b1;
        else start_st = 1'b1;
        @(posedge Clk);
        t0 = $time;
        ev_st.delete();
        ev_mo.delete();
        @(negedge Clk);
        start_st = 1'b0;
        start_mo = 1'b0;
    endtask

    task automatic wait_end(input bit mono, input int obs, input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && busy_of(mono) && ev_count(mono) < obs) begin
            @(negedge Clk);
            n++;
        end
        check_output({name, " in budget"}, longint'(n < budget), 64'd1);
        if (busy_of(mono)) begin
            stop = 1'b1;
            @(negedge Clk);
            stop = 1'b0;
        end
        @(negedge Clk);
    endtask

    task automatic wait_frames(input bit mono, input int n, input int budget, input string name);
        int c;
        c = 0;
        while (c < budget && ev_count(mono) < n) begin
            @(negedge Clk);
            c++;
        end
        check_output({name, " frame seen"}, longint'(c < budget), 64'd1);
    endtask

    task automatic apply_stimulus(input bit mono, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                                  input logic [15:0] div, input bit lp, input int obs,
                                  input int budget, input string name, output longint t0);
        launch(mono, sa, ea, div, lp, t0);
        wait_end(mono, obs, budget, name);
    endtask

    // Reference model: frame k carries words start+k*nch.., padded with 0 past the window, at (k+1)*E cycles.
    task automatic check_run(input string name, input bit mono, input int sa, input int ea,
                             input int div, input bit lp, input int obs, input longint t0);
        int nch, e, nfr, exp_n, got_n, fi;
        longint base;
        logic [15:0] el, er;
        ev_t ev;
        nch   = mono ? 1 : 2;
        e     = (div > nch * 2 + 2) ? div : nch * 2 + 2;
        nfr   = (ea - sa + 1 + nch - 1) / nch;
        exp_n = lp ? obs : nfr;
        got_n = ev_count(mono);
        check_output({name, " frames"}, longint'(got_n), longint'(exp_n));
        for (int k = 0; k < got_n && k < exp_n; k++) begin
            ev   = ev_get(mono, k);
            fi   = lp ? k % nfr : k;
            base = longint'(sa) + longint'(fi * nch);
            el   = mem_word(base);
            er   = mono ? el : ((base + 1 <= longint'(ea)) ? mem_word(base + 1) : 16'h0);
            check_output($sformatf("%s f%0d time", name, k), (ev.t - t0 - 5) / 10, longint'((k + 1) * e));
            check_output($sformatf("%s f%0d ldata", name, k), longint'(ev.l), longint'(el));
            check_output($sformatf("%s f%0d rdata", name, k), longint'(ev.r), longint'(er));
            check_output($sformatf("%s f%0d done", name, k), longint'(ev.d), longint'(!lp && k == nfr - 1));
        end
    endtask

    initial begin
        vec_t   vecs[7];
        longint t0;
        int     n, dones, sa, ea, div, obs;
        bit     lp, mono;
        ev_t    e0, e1, e2;

        vecs[0] = '{20'h10,    20'h15,    16'd20, 1'b0, 1000, 3, 20, 16'h0014, 16'h0015, 1};
        vecs[1] = '{20'h10,    20'h15,    16'd20, 1'b1, 4,    4, 20, 16'h0010, 16'h0011, 0};
        vecs[2] = '{20'h10,    20'h15,    16'd2,  1'b0, 1000, 3, 6,  16'h0014, 16'h0015, 1};
        vecs[3] = '{20'h20,    20'h24,    16'd12, 1'b0, 1000, 3, 12, 16'h0024, 16'h0000, 1};
        vecs[4] = '{20'hFFFFC, 20'hFFFFF, 16'd8,  1'b0, 1000, 2, 8,  16'hFFFE, 16'hFFFF, 1};
        vecs[5] = '{20'h50,    20'h50,    16'd7,  1'b0, 1000, 1, 7,  16'h0050, 16'h0000, 1};
        vecs[6] = '{20'h30,    20'h20,    16'd20, 1'b0, 1000, 0, 20, 16'h0000, 16'h0000, 0};

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_output("reset busy", longint'(busy_st), 64'd0);
        check_output("reset ldata", longint'(ld_st), 64'd0);
        check_output("reset rdata", longint'(rd_st), 64'd0);
        check_output("reset frame_valid", longint'(fv_st), 64'd0);
        check_output("reset done", longint'(done_st), 64'd0);
        check_output("reset sram_addr", longint'(bus_st.sram_addr), 64'd0);
        check_output("reset we_n", longint'(bus_st.sram_we_n), 64'd1);
        check_output("reset ce_oe_ub_lb", longint'({bus_st.sram_ce_n, bus_st.sram_oe_n, bus_st.sram_ub_n, bus_st.sram_lb_n}), 64'd0);
        check_output("reset mono busy", longint'(busy_mo), 64'd0);
        Reset = 1'b0;
        mix = '0;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, vecs[i].sa, vecs[i].ea, vecs[i].div, vecs[i].lp, vecs[i].obs, 1000,
                           $sformatf("vec%0d", i), t0);
            n = ev_count(1'b0);
            check_output($sformatf("vec%0d frames", i), longint'(n), longint'(vecs[i].exp_frames));
            if (n > 0) begin
                e0 = ev_get(1'b0, 0);
                e1 = ev_get(1'b0, n - 1);
                check_output($sformatf("vec%0d latency", i), (e0.t - t0 - 5) / 10, longint'(vecs[i].exp_spacing));
                check_output($sformatf("vec%0d last ldata", i), longint'(e1.l), longint'(vecs[i].exp_l));
                check_output($sformatf("vec%0d last rdata", i), longint'(e1.r), longint'(vecs[i].exp_r));
            end
            if (n > 1) begin
                e0 = ev_get(1'b0, n - 2);
                check_output($sformatf("vec%0d spacing", i), (e1.t - e0.t) / 10, longint'(vecs[i].exp_spacing));
            end
            dones = 0;
            for (int k = 0; k < n; k++) begin
                e0 = ev_get(1'b0, k);
                dones += int'(e0.d);
            end
            check_output($sformatf("vec%0d dones", i), longint'(dones), longint'(vecs[i].exp_dones));
        end

        // Pause for 50 cycles in WAIT stretches exactly one frame interval.
        launch(1'b0, 20'h10, 20'h15, 16'd20, 1'b0, t0);
        wait_frames(1'b0, 1, 100, "pause");
        repeat (8) @(negedge Clk);
        pause = 1'b1;
        repeat (25) @(negedge Clk);
        check_output("pause sram_addr held", longint'(bus_st.sram_addr), 64'h14);
        check_output("pause busy", longint'(busy_st), 64'd1);
        repeat (25) @(negedge Clk);
        pause = 1'b0;
        wait_end(1'b0, 1000, 500, "pause");
        check_output("pause frames", longint'(ev_count(1'b0)), 64'd3);
        if (ev_count(1'b0) == 3) begin
            e0 = ev_get(1'b0, 0);
            e1 = ev_get(1'b0, 1);
            e2 = ev_get(1'b0, 2);
            check_output("pause stretched interval", (e1.t - e0.t) / 10, 64'd70);
            check_output("pause next interval", (e2.t - e1.t) / 10, 64'd20);
            check_output("pause f1 ldata", longint'(e1.l), 64'h12);
            check_output("pause f1 rdata", longint'(e1.r), 64'h13);
            check_output("pause done", longint'(e2.d), 64'd1);
        end

        // Stop during FETCH clears outputs and suppresses done.
        launch(1'b0, 20'h10, 20'h15, 16'd20, 1'b0, t0);
        wait_frames(1'b0, 1, 100, "stop");
        repeat (2) @(negedge Clk);
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        check_output("stop busy", longint'(busy_st), 64'd0);
        check_output("stop ldata", longint'(ld_st), 64'd0);
        check_output("stop rdata", longint'(rd_st), 64'd0);
        repeat (60) @(negedge Clk);
        check_output("stop no more frames", longint'(ev_count(1'b0)), 64'd1);

        // Stop wins over a simultaneous start.
        launch(1'b0, 20'h10, 20'h15, 16'd20, 1'b0, t0);
        repeat (5) @(negedge Clk);
        stop = 1'b1;
        start_st = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        start_st = 1'b0;
        check_output("stop over start busy", longint'(busy_st), 64'd0);

        // A reversed window never leaves IDLE.
        launch(1'b0, 20'h30, 20'h20, 16'd20, 1'b0, t0);
        check_output("reversed window busy", longint'(busy_st), 64'd0);
        repeat (40) @(negedge Clk);
        check_output("reversed window frames", longint'(ev_count(1'b0)), 64'd0);

        // Restart while busy.
        launch(1'b0, 20'h10, 20'h15, 16'd20, 1'b0, t0);
        repeat (30) @(negedge Clk);
        apply_stimulus(1'b0, 20'h40, 20'h43, 16'd9, 1'b0, 1000, 500, "restart", t0);
        check_run("restart", 1'b0, 'h40, 'h43, 9, 1'b0, 1000, t0);

        // Reset mid-frame.
        launch(1'b0, 20'h10, 20'h15, 16'd20, 1'b0, t0);
        wait_frames(1'b0, 1, 100, "midreset");
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_output("midreset busy", longint'(busy_st), 64'd0);
        check_output("midreset ldata", longint'(ld_st), 64'd0);
        check_output("midreset rdata", longint'(rd_st), 64'd0);
        check_output("midreset frame_valid", longint'(fv_st), 64'd0);
        check_output("midreset sram_addr", longint'(bus_st.sram_addr), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Mono at the 44.1 kHz divider and at the top of the address space.
        mix = 16'h5A3C;
        apply_stimulus(1'b1, 20'h0, 20'h2, 16'(DIV_44K1), 1'b0, 1000, 5000, "mono44k", t0);
        check_run("mono44k", 1'b1, 0, 2, DIV_44K1, 1'b0, 1000, t0);
        apply_stimulus(1'b1, 20'hFFFFD, 20'hFFFFF, 16'd10, 1'b0, 1000, 500, "monotop", t0);
        check_run("monotop", 1'b1, 'hFFFFD, 'hFFFFF, 10, 1'b0, 1000, t0);

        for (int i = 0; i < 16; i++) begin
            mono = (i % 2) == 1;
            mix  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ea = 'hFFFFF - int'($urandom_range(0, 1));
                sa = ea - int'($urandom_range(0, 6));
            end else begin
                sa = int'($urandom_range(0, 'hFFFF0));
                ea = sa + int'($urandom_range(0, 9));
            end
            div = int'($urandom_range(1, 28));
            lp  = $urandom_range(0, 1) == 1;
            obs = lp ? int'($urandom_range(2, 8)) : 1000;
            apply_stimulus(mono, AW'(sa), AW'(ea), 16'(div), lp, obs, 3000, $sformatf("rand%0d", i), t0);
            check_run($sformatf("rand%0d", i), mono, sa, ea, div, lp, obs, t0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_pcm_player.md
Name: sram_pcm_player

Overview:
- Streams 16-bit PCM from asynchronous SRAM to the audio codec interface's LDATA/RDATA inputs at a programmable sample rate.
- Generalised successor to the fixed-address, fixed-rate mono player:
  - programmable start/end window;
  - mono or interleaved stereo;
  - loop/one-shot, pause and stop;
  - configurable SRAM read wait states.
- Sits between the SRAM pins and audio_interface, controlled by game/top-level logic.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width (equals SRAM word width).
- NUM_CH, 2, channels per frame: 1 = mono (one word per frame), 2 = stereo (L word then R word, consecutive addresses).
- DIV_W, 16, width of the rate divider.
- SRAM_WAIT, 1, extra Clk cycles that an address must be held before DQ is sampled.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin playback at start_addr.
- stop  in  1  abort playback; return to IDLE.
- pause  in  1  level; freezes the frame counter and address while high.
- loop_en  in  1  level; at end of window, wrap to start_addr instead of finishing.
- start_addr  in  ADDR_W  first word of the clip; sampled on start.
- end_addr  in  ADDR_W  last word of the clip, inclusive; sampled on start.
- rate_div  in  DIV_W  Clk cycles per frame (1134 gives 44.1 kHz); sampled on start.
- sram_addr  out  ADDR_W  SRAM address.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM controls.
- sram_dq  in  DATA_W  SRAM read data.
- ldata, rdata  out  DATA_W  current frame to the codec.
- frame_valid  out  1  one-cycle pulse when ldata/rdata update.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on natural end of a one-shot clip.

Behaviour:
- Reset values:
  - state IDLE; sram_addr 0; ldata/rdata 0; frame_valid/done/busy 0.
  - sram_ce_n/oe_n/ub_n/lb_n 0; sram_we_n 1. The controls are constant; the block never writes.
- Latched on start: start_addr, end_addr, rate_div.
  - Effective divider = max(rate_div, NUM_CH*(SRAM_WAIT+1)+2).
  - If end_addr < start_addr, start is ignored.
- FSM: IDLE, FETCH, WAIT.
- IDLE:
  - On start, ptr <= start_addr, ch <= 0, div_cnt <= 0, go to FETCH.
  - stop and pause are ignored in IDLE.
- FETCH:
  - sram_addr = ptr, held SRAM_WAIT+1 cycles.
  - On the last hold cycle, latch sram_dq into the staging register for channel ch, then ptr++.
  - If ch < NUM_CH-1: ch++ and stay in FETCH.
  - Otherwise go to WAIT.
  - Incomplete frame: if ptr passes end_addr mid-frame, the remaining channels latch 0.
- WAIT:
  - On the cycle div_cnt == effective_div-1:
    - copy staging to ldata/rdata, pulse frame_valid, div_cnt <= 0.
    - Then, if ptr > end_addr: with loop_en, set ptr <= start_addr and go to FETCH; without loop_en, pulse done and go to IDLE.
    - Otherwise go to FETCH with ch <= 0.
  - div_cnt increments every unpaused cycle in FETCH and WAIT, so frames are exactly effective_div cycles apart.
- Mono (NUM_CH=1): rdata = ldata = the single word.
- First frame: frame_valid first asserts effective_div cycles after the start cycle.
- pause high: div_cnt, ptr, ch and state hold; ldata/rdata hold; no frame_valid. An in-progress FETCH hold count also freezes.
- stop (any non-IDLE state): go to IDLE next cycle; ldata/rdata <= 0; no done pulse. stop has priority over pause and start.
- start while busy: restarts from the newly latched start_addr, same as from IDLE. stop has priority over start.
- Address arithmetic: ADDR_W bits, unsigned. At end_addr == 2^ADDR_W-1, end detection uses an extra carry bit, so it does not wrap silently.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- VOLUME_EN defined:
  - Adds input port volume_shift [3:0].
  - Each output sample = staging value arithmetic-shifted right by volume_shift (signed two's complement), applied at frame latch.
  - volume_shift >= 15 yields 0 or -1 as per sign.
- VOLUME_EN not defined: no port; samples pass unmodified.

Decomposition:
- Package sram_audio_pkg: state enum (IDLE, FETCH, WAIT), ADDR_W/DATA_W defaults, constant DIV_44K1 = 1134, constant DIV_22K05 = 2268.
- One sub-module, pcm_rate_divider: div_cnt, pause gating, tick output. The FSM stays in sram_pcm_player.

Test Plan:
- NUM_CH=2, SRAM model mem[i]=i, start_addr=0x10, end_addr=0x15, rate_div=20, loop_en=0 → three frame_valid pulses 20 cycles apart with (L,R) = (0x10,0x11), (0x12,0x13), (0x14,0x15); done pulses with the third; busy then 0.
- Same setup with loop_en=1 → the fourth frame is (0x10,0x11); no done pulse.
- NUM_CH=1, rate_div=1134, start_addr=0, end_addr=0x948B8 → ldata==rdata on every frame; frames 1134 cycles apart; done pulses after 0x948B9 frames (the original clip, now parameterised).
- pause held 50 cycles mid-WAIT → the next frame_valid is delayed by exactly 50 cycles; ptr unchanged.
- stop during FETCH → IDLE next cycle, ldata=rdata=0, no done; end_addr<start_addr on start → stays IDLE.
- rate_div=2 with NUM_CH=2, SRAM_WAIT=1 → frames spaced 6 cycles (clamped); Reset asserted mid-frame → all outputs at reset values next cycle.
